regfile_wb: RTL and testbench

- General-purpose register file (32 x 32-bit) of the pipelined MIPS32 core.
- Receiving end of the write-back interface driven by the MEM/WB pipeline register: accepts the destination index, write-enable and write data each cycle and commits them to storage.
- Serves two operand read ports to the ID stage and one debug read port to the bench/trace logic.
- Write-to-read bypass is built in, so an ID-stage read in the same cycle as a WB write to the same register returns the new value.

---
 rtl/regfile_wb_if.sv | 35 +++
 rtl/regfile_wb.sv | 94 +++++++++
 tb/tb_regfile_wb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Write-back / operand-read bundle between the pipeline stages and the
// general-purpose register file. The slave modport is the register file.
`timescale 1ns/1ps
interface regfile_wb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // write-back channel from the MEM/WB register
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  // operand read port 1
  logic                  re1;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [DATA_WIDTH-1:0] rdata1;
  // operand read port 2
  logic                  re2;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata2;
  // debug/trace read port (committed state only)
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, re2, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data
  );

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, re2, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data
  );
endinterface

// File: rtl/regfile_wb.sv
// 32 x 32-bit general-purpose register file for the MIPS32 pipeline.
// One write-back port, two bypassed operand read ports, one debug read port.
// r0 has no storage and always reads zero.
`timescale 1ns/1ps
module regfile_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic          clk,
  input  logic          rst,
  regfile_wb_if.slave   bus
);

  // Every index must map onto a real register.
  if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_param_check
    $error("regfile_wb: NUM_REGS must equal 2**ADDR_WIDTH");
  end

  // Committed register contents, index 0 hard-wired to zero.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // One-hot write select; r0 is never selected.
  logic [NUM_REGS-1:0] wr_sel_d;

  // Decode the write-back destination into a per-register enable.
  always_comb begin
    wr_sel_d = '0;
    if (bus.we && (bus.waddr != '0)) begin
      wr_sel_d[bus.waddr] = 1'b1;
    end
  end

  // Per-register storage; asynchronous reset clears every entry at once and
  // also discards a write presented on an edge while reset is high.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] reg_q;

      // Commit write data when this register is the write-back target.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else if (wr_sel_d[gi]) begin
          reg_q <= bus.wdata;
        end
      end

      assign regs[gi] = reg_q;
    end
  end

  // Operand read rule shared by both ports: reset, disabled and r0 read zero;
  // a concurrent write to the same index is forwarded (write-first).
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  rst_f,
    input logic                  re_f,
    input logic [ADDR_WIDTH-1:0] raddr_f,
    input logic                  we_f,
    input logic [ADDR_WIDTH-1:0] waddr_f,
    input logic [DATA_WIDTH-1:0] wdata_f,
    input logic [DATA_WIDTH-1:0] stored_f
  );
    logic [DATA_WIDTH-1:0] result;
    if (rst_f || !re_f || (raddr_f == '0)) begin
      result = '0;
    end else if (we_f && (waddr_f == raddr_f)) begin
      result = wdata_f;
    end else begin
      result = stored_f;
    end
    return result;
  endfunction

  // Operand port 1 with same-cycle write-back forwarding.
  always_comb begin
    bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.we, bus.waddr,
                           bus.wdata, regs[bus.raddr1]);
  end

  // Operand port 2 with same-cycle write-back forwarding.
  always_comb begin
    bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.we, bus.waddr,
                           bus.wdata, regs[bus.raddr2]);
  end

  // Debug port shows committed state only, never the in-flight write.
  always_comb begin
    bus.dbg_data = rst ? '0 : regs[bus.dbg_addr];
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus a randomized
// run against an array-based reference model of the register file.
`timescale 1ns/1ps
module tb_regfile_wb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk;
  logic rst;

  regfile_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference contents of the architectural registers.
  logic [DW-1:0] model [NR];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected operand read from the architectural rules.
  function automatic logic [DW-1:0] exp_read(input logic re, input logic [AW-1:0] ra);
    if (rst || !re || ra == 0) return '0;
    if (bus.we && bus.waddr == ra) return bus.wdata;
    return model[ra];
  endfunction

  // Advance one clock: commit into the model on the rising edge, return at the
  // falling edge so stimulus changes are away from the active edge.
  task automatic tick();
    @(posedge clk);
    if (!rst && bus.we && bus.waddr != 0) model[bus.waddr] = bus.wdata;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0;
    bus.re2 = 1'b0; bus.raddr2 = '0;
    bus.dbg_addr = '0;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW-1:0] ra;
    for (int i = 1; i < 6; i++) write_reg(AW'(i * 5), $urandom);
    // assert reset between edges, with a bypass-looking write presented
    #2;
    rst = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    ra = AW'($urandom_range(1, NR - 1));
    bus.re1 = 1'b1; bus.re2 = 1'b1; bus.raddr1 = ra; bus.raddr2 = 5;
    bus.we = 1'b1; bus.waddr = ra; bus.wdata = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (bus.rdata1 !== '0) begin
      n_fail++; $display("FAIL reset_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
    end
    n_checks++;
    if (bus.rdata2 !== '0) begin
      n_fail++; $display("FAIL reset_rdata2 got=%h exp=%h", bus.rdata2, 32'h0);
    end
    for (int i = 0; i < NR; i++) begin
      bus.dbg_addr = AW'(i);
      #0.1;
      n_checks++;
      if (bus.dbg_data !== '0) begin
        n_fail++; $display("FAIL reset_dbg[%0d] got=%h exp=%h", i, bus.dbg_data, 32'h0);
      end
    end
    tick();  // edge with reset high: write must be dropped
    idle_inputs();
    rst = 1'b0;
    bus.dbg_addr = ra;
    #1;
    n_checks++;
    if (bus.dbg_data !== '0) begin
      n_fail++; $display("FAIL reset_write_dropped got=%h exp=%h", bus.dbg_data, 32'h0);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    write_reg(5, 32'h1234_5678);
    bus.re1 = 1'b1; bus.raddr1 = 5; bus.dbg_addr = 5;
    #1;
    n_checks++;
    if (bus.rdata1 !== 32'h1234_5678) begin
      n_fail++; $display("FAIL basic_rdata1 got=%h exp=%h", bus.rdata1, 32'h1234_5678);
    end
    n_checks++;
    if (bus.dbg_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL basic_dbg got=%h exp=%h", bus.dbg_data, 32'h1234_5678);
    end
    idle_inputs();
    $display("test_basic done");
  endtask

  task automatic test_r0();
    bus.we = 1'b1; bus.waddr = 0; bus.wdata = 32'hFFFF_FFFF;
    bus.re1 = 1'b1; bus.raddr1 = 0; bus.dbg_addr = 0;
    #1;
    n_checks++;
    if (bus.rdata1 !== '0) begin
      n_fail++; $display("FAIL r0_same_cycle_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
    end
    n_checks++;
    if (bus.dbg_data !== '0) begin
      n_fail++; $display("FAIL r0_same_cycle_dbg got=%h exp=%h", bus.dbg_data, 32'h0);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_checks++;
    if (bus.rdata1 !== '0) begin
      n_fail++; $display("FAIL r0_after_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
    end
    n_checks++;
    if (bus.dbg_data !== '0) begin
      n_fail++; $display("FAIL r0_after_dbg got=%h exp=%h", bus.dbg_data, 32'h0);
    end
    idle_inputs();
    $display("test_r0 done");
  endtask

  task automatic test_bypass();
    write_reg(7, 32'hAAAA_0000);
    bus.we = 1'b1; bus.waddr = 7; bus.wdata = 32'h0000_BBBB;
    bus.re1 = 1'b1; bus.re2 = 1'b1; bus.raddr1 = 7; bus.raddr2 = 7; bus.dbg_addr = 7;
    #1;
    n_checks++;
    if (bus.rdata1 !== 32'h0000_BBBB) begin
      n_fail++; $display("FAIL bypass_rdata1 got=%h exp=%h", bus.rdata1, 32'h0000_BBBB);
    end
    n_checks++;
    if (bus.rdata2 !== 32'h0000_BBBB) begin
      n_fail++; $display("FAIL bypass_rdata2 got=%h exp=%h", bus.rdata2, 32'h0000_BBBB);
    end
    n_checks++;
    if (bus.dbg_data !== 32'hAAAA_0000) begin
      n_fail++; $display("FAIL bypass_dbg_old got=%h exp=%h", bus.dbg_data, 32'hAAAA_0000);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'h0000_BBBB) begin
      n_fail++; $display("FAIL bypass_dbg_new got=%h exp=%h", bus.dbg_data, 32'h0000_BBBB);
    end
    idle_inputs();
    $display("test_bypass done");
  endtask

  task automatic test_re_gating();
    write_reg(3, 32'hDEAD_BEEF);
    bus.re2 = 1'b0; bus.raddr2 = 3;
    #1;
    n_checks++;
    if (bus.rdata2 !== '0) begin
      n_fail++; $display("FAIL re2_low got=%h exp=%h", bus.rdata2, 32'h0);
    end
    bus.re2 = 1'b1;
    #1;
    n_checks++;
    if (bus.rdata2 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL re2_high got=%h exp=%h", bus.rdata2, 32'hDEAD_BEEF);
    end
    idle_inputs();
    $display("test_re_gating done");
  endtask

  task automatic test_reset_mid();
    write_reg(9, 32'h5555_5555);
    bus.we = 1'b1; bus.waddr = 9; bus.wdata = 32'h6666_6666;
    #2;
    rst = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    tick();
    idle_inputs();
    rst = 1'b0;
    bus.dbg_addr = 9;
    #1;
    n_checks++;
    if (bus.dbg_data !== '0) begin
      n_fail++; $display("FAIL reset_mid_dbg9 got=%h exp=%h", bus.dbg_data, 32'h0);
    end
    write_reg(9, 32'h7777_7777);
    bus.re1 = 1'b1; bus.raddr1 = 9; bus.dbg_addr = 9;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'h7777_7777) begin
      n_fail++; $display("FAIL reset_mid_dbg_rewrite got=%h exp=%h", bus.dbg_data, 32'h7777_7777);
    end
    n_checks++;
    if (bus.rdata1 !== 32'h7777_7777) begin
      n_fail++; $display("FAIL reset_mid_rdata1_rewrite got=%h exp=%h", bus.rdata1, 32'h7777_7777);
    end
    idle_inputs();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [DW-1:0] e1, e2, ed;
    for (int t = 0; t < 400; t++) begin
      bus.we     = ($urandom_range(0, 3) != 0);
      bus.waddr  = AW'($urandom);
      bus.wdata  = $urandom;
      bus.re1    = ($urandom_range(0, 7) != 0);
      bus.re2    = ($urandom_range(0, 7) != 0);
      bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : AW'($urandom);
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.raddr1 : AW'($urandom);
      bus.dbg_addr = ($urandom_range(0, 3) == 0) ? bus.waddr : AW'($urandom);
      #1;
      e1 = exp_read(bus.re1, bus.raddr1);
      e2 = exp_read(bus.re2, bus.raddr2);
      ed = model[bus.dbg_addr];
      n_checks++;
      if (bus.rdata1 !== e1) begin
        n_fail++; $display("FAIL rand_rdata1 t=%0d ra=%0d got=%h exp=%h", t, bus.raddr1, bus.rdata1, e1);
      end
      n_checks++;
      if (bus.rdata2 !== e2) begin
        n_fail++; $display("FAIL rand_rdata2 t=%0d ra=%0d got=%h exp=%h", t, bus.raddr2, bus.rdata2, e2);
      end
      n_checks++;
      if (bus.dbg_data !== ed) begin
        n_fail++; $display("FAIL rand_dbg t=%0d a=%0d got=%h exp=%h", t, bus.dbg_addr, bus.dbg_data, ed);
      end
      tick();
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_r0();
    test_bypass();
    test_re_gating();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
